// File: rtl/mm_initiator_pkg.sv
// Shared encodings for the memory-mapped bus initiator: command ops, FSM states
// and the log2 helper used to size the poll attempt counter.
package mm_initiator_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_WR = 3'd1,
        ST_ISSUE_RD = 3'd2,
        ST_WAIT_RD  = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

    // Bits needed to hold values 0..value-1 (minimum 1); callers pass N+1 to hold N.
    function automatic int log2(input int value);
        int result;
        int pow;
        result = 1;
        pow    = 1;
        for (int i = 1; i < 31; i++) begin
            pow = pow * 2;
            if (pow < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mm_initiator.sv
// Single-outstanding-command initiator for the memory-mapped register port:
// write, read and poll-until-match, with registered bus strobes and fields.
module mm_initiator
    import mm_initiator_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int POLL_LIMIT = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_WIDTH-1:0]   cmd_address,
    input  logic [DATA_WIDTH-1:0]   cmd_writeData,
    input  logic [DATA_WIDTH/8-1:0] cmd_byteEnable,
    input  logic [DATA_WIDTH-1:0]   cmd_mask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    resp_timeout,
    output logic                    readEnable,
    output logic                    writeEnable,
    output logic [DATA_WIDTH/8-1:0] writeByteEnable,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH-1:0]   readData
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = log2(POLL_LIMIT + 1);

    state_e                  state_r;
    state_e                  state_nxt_s;
    op_e                     op_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [BE_W-1:0]         be_r;
    logic [DATA_WIDTH-1:0]   mask_r;
    logic [CNT_W-1:0]        cnt_r;

    logic                    accept_s;
    logic                    poll_match_s;
    logic                    cnt_last_s;
    logic                    is_poll_s;
    logic [ADDR_WIDTH-1:0]   addr_src_s;
    logic [DATA_WIDTH-1:0]   wdata_src_s;
    logic [BE_W-1:0]         be_src_s;

    assign accept_s     = cmd_valid && (state_r == ST_IDLE);
    assign is_poll_s    = (op_r == OP_POLL);
    // The compare value travels in the write-data register for polls.
    assign poll_match_s = (((readData ^ wdata_r) & mask_r) == {DATA_WIDTH{1'b0}});
    assign cnt_last_s   = (cnt_r == CNT_W'(1));
    assign addr_src_s   = (state_r == ST_IDLE) ? cmd_address    : addr_r;
    assign wdata_src_s  = (state_r == ST_IDLE) ? cmd_writeData  : wdata_r;
    assign be_src_s     = (state_r == ST_IDLE) ? cmd_byteEnable : be_r;

    // Next-state decode for the command sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (op_e'(cmd_op))
                        OP_WRITE: state_nxt_s = ST_ISSUE_WR;
                        OP_READ:  state_nxt_s = ST_ISSUE_RD;
                        OP_POLL:  state_nxt_s = ST_ISSUE_RD;
                        default:  state_nxt_s = ST_RESP;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE_WR: state_nxt_s = ST_RESP;
            ST_ISSUE_RD: state_nxt_s = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (is_poll_s && !poll_match_s && !cnt_last_s) begin
                    state_nxt_s = ST_ISSUE_RD;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command latch and poll attempt counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            op_r    <= OP_WRITE;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
            be_r    <= {BE_W{1'b0}};
            mask_r  <= {DATA_WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            op_r    <= op_e'(cmd_op);
            addr_r  <= cmd_address;
            wdata_r <= cmd_writeData;
            be_r    <= cmd_byteEnable;
            mask_r  <= cmd_mask;
            cnt_r   <= CNT_W'(POLL_LIMIT);
        end else if (state_r == ST_WAIT_RD && is_poll_s && !poll_match_s) begin
            cnt_r   <= cnt_r - CNT_W'(1);
        end
    end

    // Bus outputs are set from the upcoming state so each strobe lasts one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            writeEnable     <= 1'b0;
            readEnable      <= 1'b0;
            address         <= {ADDR_WIDTH{1'b0}};
            writeData       <= {DATA_WIDTH{1'b0}};
            writeByteEnable <= {BE_W{1'b0}};
        end else begin
            writeEnable     <= (state_nxt_s == ST_ISSUE_WR);
            readEnable      <= (state_nxt_s == ST_ISSUE_RD);
            address         <= (state_nxt_s == ST_ISSUE_WR || state_nxt_s == ST_ISSUE_RD)
                               ? addr_src_s : {ADDR_WIDTH{1'b0}};
            writeData       <= (state_nxt_s == ST_ISSUE_WR) ? wdata_src_s : {DATA_WIDTH{1'b0}};
            writeByteEnable <= (state_nxt_s == ST_ISSUE_WR) ? be_src_s : {BE_W{1'b0}};
        end
    end

    // Handshake flags and response payload.
    always_ff @(posedge clock) begin
        if (reset) begin
            cmd_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_data    <= {DATA_WIDTH{1'b0}};
            resp_timeout <= 1'b0;
        end else begin
            cmd_ready  <= (state_nxt_s == ST_IDLE);
            resp_valid <= (state_nxt_s == ST_RESP);
            if (accept_s) begin
                resp_data    <= {DATA_WIDTH{1'b0}};
                resp_timeout <= 1'b0;
            end else if (state_r == ST_WAIT_RD) begin
                resp_data    <= readData;
                resp_timeout <= is_poll_s && !poll_match_s && cnt_last_s;
            end
        end
    end

endmodule

// File: tb/tb_mm_initiator.sv
// Directed bench: two initiators (POLL_LIMIT 16 and 4) sharing command stimulus,
// each driving a 4-register byte-enabled responder modelled here.
module tb_mm_initiator;
    import mm_initiator_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        use4 = 1'b0;
    logic        arm = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [7:0]  cmd_address = 8'h00;
    logic [31:0] cmd_wdata = 32'h0;
    logic [3:0]  cmd_be = 4'h0;
    logic [31:0] cmd_mask = 32'h0;
    logic        resp_ready = 1'b0;
    int total = 0;
    int bad = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;

    logic        cr_a, rv_a, to_a, re_a, we_a, cr_b, rv_b, to_b, re_b, we_b;
    logic [31:0] rd_a, wd_a, bus_rd_a, rd_b, wd_b, bus_rd_b;
    logic [7:0]  ad_a, ad_b;
    logic [3:0]  be_a, be_b;
    logic [31:0] regs_a [4];
    logic [31:0] regs_b [4];
    int          arm_cnt;

    logic        m_cr, m_rv, m_to, m_re, m_we;
    logic [31:0] m_rd, m_wd;
    logic [7:0]  m_ad;
    logic [3:0]  m_be;
    assign m_cr = use4 ? cr_b : cr_a;
    assign m_rv = use4 ? rv_b : rv_a;
    assign m_to = use4 ? to_b : to_a;
    assign m_re = use4 ? re_b : re_a;
    assign m_we = use4 ? we_b : we_a;
    assign m_rd = use4 ? rd_b : rd_a;
    assign m_wd = use4 ? wd_b : wd_a;
    assign m_ad = use4 ? ad_b : ad_a;
    assign m_be = use4 ? be_b : be_a;

    always #5 clk = ~clk;

    mm_initiator #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .POLL_LIMIT(16)) dut (
        .clock(clk), .reset(reset), .cmd_valid(cmd_valid && !use4), .cmd_ready(cr_a),
        .cmd_op(cmd_op), .cmd_address(cmd_address), .cmd_writeData(cmd_wdata),
        .cmd_byteEnable(cmd_be), .cmd_mask(cmd_mask), .resp_valid(rv_a),
        .resp_ready(resp_ready && !use4), .resp_data(rd_a), .resp_timeout(to_a),
        .readEnable(re_a), .writeEnable(we_a), .writeByteEnable(be_a), .address(ad_a),
        .writeData(wd_a), .readData(bus_rd_a));

    mm_initiator #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .POLL_LIMIT(4)) dut4 (
        .clock(clk), .reset(reset), .cmd_valid(cmd_valid && use4), .cmd_ready(cr_b),
        .cmd_op(cmd_op), .cmd_address(cmd_address), .cmd_writeData(cmd_wdata),
        .cmd_byteEnable(cmd_be), .cmd_mask(cmd_mask), .resp_valid(rv_b),
        .resp_ready(resp_ready && use4), .resp_data(rd_b), .resp_timeout(to_b),
        .readEnable(re_b), .writeEnable(we_b), .writeByteEnable(be_b), .address(ad_b),
        .writeData(wd_b), .readData(bus_rd_b));

    // Responder A; when armed, a second writer sets reg0 bit 0 right after the 5th read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) regs_a[i] <= 32'h0;
            bus_rd_a <= 32'h0;
            arm_cnt  <= 0;
        end else begin
            if (we_a) begin
                for (int b = 0; b < 4; b++) if (be_a[b]) regs_a[ad_a[1:0]][8*b +: 8] <= wd_a[8*b +: 8];
            end
            if (re_a) bus_rd_a <= regs_a[ad_a[1:0]];
            if (!arm) arm_cnt <= 0;
            else if (re_a) arm_cnt <= arm_cnt + 1;
            if (arm && re_a && arm_cnt == 4) regs_a[0][0] <= 1'b1;
        end
    end

    // Responder B, plain register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) regs_b[i] <= 32'h0;
            bus_rd_b <= 32'h0;
        end else begin
            if (we_b) begin
                for (int b = 0; b < 4; b++) if (be_b[b]) regs_b[ad_b[1:0]][8*b +: 8] <= wd_b[8*b +: 8];
            end
            if (re_b) bus_rd_b <= regs_b[ad_b[1:0]];
        end
    end

    // Strobe pulse counters for the selected initiator.
    always_ff @(posedge clk) begin
        if (m_re) rd_pulses <= rd_pulses + 1;
        if (m_we) wr_pulses <= wr_pulses + 1;
    end

    // Present a command for one accepting edge; returns in cycle T+1.
    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] mask);
        cmd_valid = 1'b1; cmd_op = op; cmd_address = a; cmd_wdata = d; cmd_be = be; cmd_mask = mask;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(input int budget, output int cycles);
        cycles = 0;
        while (!m_rv && cycles < budget) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        total++; if (m_cr !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", m_cr); end
        total++; if (m_rv !== 1'b0 || m_to !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b%b exp=00", m_rv, m_to); end
        total++; if (m_rd !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h exp=0", m_rd); end
        total++; if ({m_re, m_we, m_ad, m_wd, m_be} !== 46'h0) begin bad++; $display("FAIL reset_bus got=%b%b %h %h %h exp=0", m_re, m_we, m_ad, m_wd, m_be); end
    endtask

    task automatic test_write_read();
        int cyc;
        send(OP_WRITE, 8'd2, 32'hDEADBEEF, 4'hF, 32'h0);
        total++; if ({m_we, m_re} !== 2'b10) begin bad++; $display("FAIL wr_strobe got=%b%b exp=10", m_we, m_re); end
        total++; if (m_ad !== 8'd2 || m_wd !== 32'hDEADBEEF || m_be !== 4'hF) begin bad++; $display("FAIL wr_fields got=%h %h %h exp=02 deadbeef f", m_ad, m_wd, m_be); end
        total++; if (m_cr !== 1'b0) begin bad++; $display("FAIL wr_busy_ready got=%b exp=0", m_cr); end
        wait_resp(20, cyc);
        total++; if (cyc !== 1) begin bad++; $display("FAIL wr_latency got=%0d exp=1", cyc); end
        total++; if (m_rd !== 32'h0 || {m_we, m_ad, m_wd, m_be} !== 45'h0) begin bad++; $display("FAIL wr_resp got=%h we=%b ad=%h exp=0", m_rd, m_we, m_ad); end
        handshake();
        total++; if (m_cr !== 1'b1 || m_rv !== 1'b0) begin bad++; $display("FAIL b2b_ready got=%b%b exp=10", m_cr, m_rv); end
        send(OP_READ, 8'd2, 32'h0, 4'hF, 32'h0);
        total++; if ({m_re, m_we} !== 2'b10 || m_ad !== 8'd2 || m_be !== 4'h0) begin bad++; $display("FAIL rd_strobe got=%b%b %h %h exp=10 02 0", m_re, m_we, m_ad, m_be); end
        wait_resp(20, cyc);
        total++; if (cyc !== 2) begin bad++; $display("FAIL rd_latency got=%0d exp=2", cyc); end
        total++; if (m_rd !== 32'hDEADBEEF || m_to !== 1'b0) begin bad++; $display("FAIL rd_data got=%h to=%b exp=deadbeef 0", m_rd, m_to); end
        handshake();
    endtask

    task automatic test_byte_enable();
        int cyc;
        send(OP_WRITE, 8'd1, 32'h12345678, 4'hF, 32'h0); wait_resp(20, cyc); handshake();
        send(OP_WRITE, 8'd1, 32'h000000AA, 4'h1, 32'h0);
        total++; if (m_be !== 4'h1 || m_wd !== 32'h000000AA) begin bad++; $display("FAIL be_fields got=%h %h exp=1 000000aa", m_be, m_wd); end
        wait_resp(20, cyc); handshake();
        send(OP_READ, 8'd1, 32'h0, 4'h0, 32'h0); wait_resp(20, cyc);
        total++; if (m_rd !== 32'h123456AA) begin bad++; $display("FAIL be_merge got=%h exp=123456aa", m_rd); end
        handshake();
    endtask

    task automatic test_poll_match();
        int cyc, p0;
        arm = 1'b1;
        p0 = rd_pulses;
        send(OP_POLL, 8'd0, 32'h1, 4'h0, 32'h1);
        wait_resp(100, cyc);
        total++; if (cyc !== 12) begin bad++; $display("FAIL poll_latency got=%0d exp=12", cyc); end
        total++; if (rd_pulses - p0 !== 6) begin bad++; $display("FAIL poll_pulses got=%0d exp=6", rd_pulses - p0); end
        total++; if (m_to !== 1'b0 || m_rd !== 32'h1) begin bad++; $display("FAIL poll_result got=%b %h exp=0 00000001", m_to, m_rd); end
        handshake();
        arm = 1'b0;
        p0 = rd_pulses;
        send(OP_POLL, 8'd3, 32'hFFFFFFFF, 4'h0, 32'h0);
        wait_resp(100, cyc);
        total++; if (cyc !== 2 || rd_pulses - p0 !== 1 || m_to !== 1'b0) begin bad++; $display("FAIL poll_zero_mask got=cyc%0d pulses%0d to%b exp=2 1 0", cyc, rd_pulses - p0, m_to); end
        handshake();
    endtask

    task automatic test_poll_timeout();
        int cyc, p0;
        use4 = 1'b1;
        send(OP_WRITE, 8'd2, 32'h5A5A0001, 4'hF, 32'h0); wait_resp(20, cyc); handshake();
        p0 = rd_pulses;
        send(OP_POLL, 8'd2, 32'h0, 4'h0, 32'hFFFFFFFF);
        wait_resp(100, cyc);
        total++; if (cyc !== 8) begin bad++; $display("FAIL timeout_latency got=%0d exp=8", cyc); end
        total++; if (rd_pulses - p0 !== 4) begin bad++; $display("FAIL timeout_pulses got=%0d exp=4", rd_pulses - p0); end
        total++; if (m_to !== 1'b1 || m_rd !== 32'h5A5A0001) begin bad++; $display("FAIL timeout_result got=%b %h exp=1 5a5a0001", m_to, m_rd); end
        handshake();
        use4 = 1'b0;
    endtask

    task automatic test_stall();
        int cyc, p0, w0;
        send(OP_READ, 8'd2, 32'h0, 4'h0, 32'h0);
        wait_resp(20, cyc);
        p0 = rd_pulses; w0 = wr_pulses;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if (m_rv !== 1'b1 || m_rd !== 32'hDEADBEEF || m_cr !== 1'b0 || m_re !== 1'b0 || m_we !== 1'b0) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=rv%b %h cr%b re%b we%b exp=rv1 deadbeef cr0 re0 we0", i, m_rv, m_rd, m_cr, m_re, m_we);
            end
        end
        total++; if (rd_pulses != p0 || wr_pulses != w0) begin bad++; $display("FAIL stall_bus got=%0d/%0d exp=0/0", rd_pulses - p0, wr_pulses - w0); end
        handshake();
    endtask

    task automatic test_rsvd();
        int p0, w0;
        p0 = rd_pulses; w0 = wr_pulses;
        send(OP_RSVD, 8'd1, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF);
        total++; if (m_rv !== 1'b1 || m_rd !== 32'h0 || m_to !== 1'b0) begin bad++; $display("FAIL rsvd_resp got=%b %h %b exp=1 0 0", m_rv, m_rd, m_to); end
        total++; if (m_re !== 1'b0 || m_we !== 1'b0 || rd_pulses != p0 || wr_pulses != w0) begin bad++; $display("FAIL rsvd_bus got=re%b we%b exp=0 0", m_re, m_we); end
        handshake();
    endtask

    task automatic test_reset_mid();
        send(OP_POLL, 8'd3, 32'h1, 4'h0, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        total++; if ({m_re, m_we, m_rv, m_to} !== 4'h0 || {m_ad, m_wd, m_be} !== 44'h0 || m_rd !== 32'h0) begin bad++; $display("FAIL midreset_outputs got=%b%b%b%b %h %h %h %h exp=0", m_re, m_we, m_rv, m_to, m_ad, m_wd, m_be, m_rd); end
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (m_cr !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b exp=1", m_cr); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if (m_rv !== 1'b0 || m_re !== 1'b0 || m_we !== 1'b0) begin bad++; $display("FAIL midreset_quiet cyc=%0d got=rv%b re%b we%b exp=0", i, m_rv, m_re, m_we); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_poll_match();
        test_poll_timeout();
        test_stall();
        test_rsvd();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
